sd_cmd_controller: RTL and testbench

Sequences one SD command transaction on the CMD line for the host core. It accepts an index, argument and response type from the host register side, and builds the 48-bit frame, including CRC7. It loads and starts parallel_to_serial, then waits for the card response start bit and hands reception to the CMD deserializer. It reports done, timeout or response-format errors, and owns the serializer's start_sending/parallel_in inputs exclusively.

---
 rtl/sd_cmd_pkg.sv | 23 ++
 rtl/sd_crc7.sv | 16 +
 rtl/sd_cmd_controller.sv | 141 ++++++++++++++
 tb/tb_sd_cmd_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared state encoding, response codes and frame constants for the SD CMD path
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RECV,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_NONE  = 2'b00;
  localparam logic [1:0] RESP_SHORT = 2'b01;
  localparam logic [1:0] RESP_LONG  = 2'b10;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - combinational CRC7 (x^7+x^3+1) over a 40-bit command head, MSB first, seed 0
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  always_comb begin
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      crc = {crc[5:0], 1'b0} ^ ({7{data[i] ^ crc[6]}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sd_cmd_controller.sv
// rtl/sd_cmd_controller.sv - sequences one SD command: frame build, serializer handoff, response wait/receive
module sd_cmd_controller
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int RX_MAX  = 255,
  parameter int CNT_W   = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         req,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         resp_err,
  output logic         start_sending,
  output logic [47:0]  parallel_out,
  input  logic         finished,
  input  logic         cmd_line_in,
  output logic         start_receiving,
  output logic         resp_long,
  input  logic         receive_done,
  input  logic [135:0] response_in,
  output logic [135:0] response
);

  localparam logic [CNT_W-1:0] NCR_LAST = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_MAX - 1);

  state_t            state;
  logic [5:0]        idx_q;
  logic [31:0]       arg_q;
  logic [1:0]        rtype_q;
  logic [CNT_W-1:0]  cnt;
  logic [39:0]       head;
  logic [6:0]        crc;

  assign head = {START_BIT, TX_BIT, idx_q, arg_q};

  sd_crc7 u_crc7 (
    .data (head),
    .crc  (crc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= ST_IDLE;
      idx_q           <= '0;
      arg_q           <= '0;
      rtype_q         <= '0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
      resp_err        <= 1'b0;
      start_sending   <= 1'b0;
      parallel_out    <= '0;
      start_receiving <= 1'b0;
      resp_long       <= 1'b0;
      response        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            idx_q       <= cmd_index;
            arg_q       <= cmd_argument;
            rtype_q     <= resp_type;
            timeout_err <= 1'b0;
            resp_err    <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          parallel_out  <= {head, crc, END_BIT};
          start_sending <= 1'b1;
          state         <= ST_SEND;
        end
        ST_SEND: begin
          // The CMD line is deliberately not looked at here; a low level
          // coinciding with finished is still our own transmission.
          if (finished) begin
            start_sending <= 1'b0;
            cnt           <= '0;
            if (rtype_q == RESP_NONE) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_WAIT_RESP;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (!cmd_line_in) begin
            start_receiving <= 1'b1;
            resp_long       <= (rtype_q == RESP_LONG);
            cnt             <= '0;
            state           <= ST_RECV;
          end else if (cnt == NCR_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECV: begin
          // Data arriving on the last allowed cycle beats the timeout.
          if (receive_done) begin
            start_receiving <= 1'b0;
            if (resp_long) begin
              response <= response_in;
            end else begin
              response <= {88'b0, response_in[47:0]};
              resp_err <= response_in[46] | ~response_in[0];
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == RX_LAST) begin
            start_receiving <= 1'b0;
            timeout_err     <= 1'b1;
            done            <= 1'b1;
            state           <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_controller.sv
// tb/tb_sd_cmd_controller.sv - randomized self-checking bench for sd_cmd_controller against a behavioural model
module tb_sd_cmd_controller;

  localparam int NCR_MAX = 64;
  localparam int RX_MAX  = 255;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         req;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         busy, done, timeout_err, resp_err;
  logic         start_sending, start_receiving, resp_long;
  logic [47:0]  parallel_out;
  logic         finished, cmd_line_in, receive_done;
  logic [135:0] response_in, response;

  int checks   = 0;
  int failures = 0;

  logic [135:0] exp_resp = '0;
  logic         exp_terr = 1'b0;
  logic         exp_rerr = 1'b0;

  always #5 CLK = ~CLK;

  sd_cmd_controller #(.NCR_MAX(NCR_MAX), .RX_MAX(RX_MAX), .CNT_W(8)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .req             (req),
    .cmd_index       (cmd_index),
    .cmd_argument    (cmd_argument),
    .resp_type       (resp_type),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err),
    .resp_err        (resp_err),
    .start_sending   (start_sending),
    .parallel_out    (parallel_out),
    .finished        (finished),
    .cmd_line_in     (cmd_line_in),
    .start_receiving (start_receiving),
    .resp_long       (resp_long),
    .receive_done    (receive_done),
    .response_in     (response_in),
    .response        (response)
  );

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // GF(2) long division of the message shifted by 7 by the full polynomial 0x89.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] rem;
    rem = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return rem[6:0];
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_ref(h), 1'b1};
  endfunction

  function automatic logic [135:0] rand136();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[135:0];
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_terr"}, timeout_err, 1'b0);
    check_eq({tag, "_rerr"}, resp_err, 1'b0);
    check_eq({tag, "_ss"}, start_sending, 1'b0);
    check_eq({tag, "_sr"}, start_receiving, 1'b0);
    check_eq({tag, "_long"}, resp_long, 1'b0);
    check_eq({tag, "_pout"}, parallel_out, 48'h0);
    check_eq({tag, "_resp"}, response, 136'h0);
  endtask

  // d: line-high cycles before the start bit (>= NCR_MAX means never)
  // r: cycles before receive_done (>= RX_MAX means never)
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int d, input int r, input logic fix, input logic [135:0] fresp,
                         input logic [47:0] golden, input logic poke_req, input logic abort);
    logic [47:0]  f;
    logic [135:0] rdata;
    int           k;
    f = frame_of(idx, arg);
    cmd_index = idx; cmd_argument = arg; resp_type = rt; req = 1'b1;
    @(negedge CLK);
    req = 1'b0; cmd_index = 6'($urandom); cmd_argument = $urandom; resp_type = 2'($urandom);
    check_eq("busy_accept", busy, 1'b1);
    check_eq("load_no_send", start_sending, 1'b0);
    check_eq("terr_clear", timeout_err, 1'b0);
    check_eq("rerr_clear", resp_err, 1'b0);
    exp_terr = 1'b0;
    exp_rerr = 1'b0;
    @(negedge CLK);
    check_eq("start_sending", start_sending, 1'b1);
    check_eq("frame", parallel_out, f);
    if (golden != 48'h0) check_eq("frame_golden", parallel_out, golden);
    repeat ($urandom_range(1, 4)) begin
      if (poke_req) begin req = 1'b1; cmd_index = ~idx; end
      @(negedge CLK);
      req = 1'b0;
      check_eq("send_hold", start_sending, 1'b1);
      check_eq("frame_stable", parallel_out, f);
    end
    finished = 1'b1;
    cmd_line_in = 1'($urandom_range(0, 1));
    @(negedge CLK);
    finished = 1'b0;
    cmd_line_in = 1'b1;
    check_eq("send_drop", start_sending, 1'b0);
    if (rt == 2'b00) begin
      check_eq("done_pulse", done, 1'b1);
    end else begin
      for (k = 0; k <= NCR_MAX + 2; k++) begin
        if (done || start_receiving) break;
        if (abort && k == 3) break;
        cmd_line_in = (k == d) ? 1'b0 : 1'b1;
        @(negedge CLK);
      end
      cmd_line_in = 1'b1;
      if (abort) begin
        check_eq("abort_in_wait", busy, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        exp_resp = '0;
        check_reset_state("abort");
        return;
      end
      check_eq("ncr_cycles", k, (d < NCR_MAX) ? d + 1 : NCR_MAX);
      if (d >= NCR_MAX) begin
        check_eq("ncr_done", done, 1'b1);
        check_eq("ncr_no_rx", start_receiving, 1'b0);
        exp_terr = 1'b1;
      end else begin
        check_eq("rx_start", start_receiving, 1'b1);
        check_eq("resp_long", resp_long, rt == 2'b10);
        rdata = fix ? fresp : rand136();
        if (!fix && $urandom_range(0, 1) == 1) begin rdata[46] = 1'b0; rdata[0] = 1'b1; end
        for (k = 0; k <= RX_MAX + 2; k++) begin
          if (done) break;
          receive_done = (k == r);
          response_in = (k == r) ? rdata : rand136();
          @(negedge CLK);
        end
        receive_done = 1'b0;
        check_eq("rx_cycles", k, (r < RX_MAX) ? r + 1 : RX_MAX);
        check_eq("rx_done", done, 1'b1);
        check_eq("rx_drop", start_receiving, 1'b0);
        if (r < RX_MAX) begin
          if (rt == 2'b10) begin
            exp_resp = rdata;
          end else begin
            exp_resp = {88'b0, rdata[47:0]};
            exp_rerr = (rdata[46] != 1'b0) || (rdata[0] != 1'b1);
          end
        end else begin
          exp_terr = 1'b1;
        end
      end
    end
    check_eq("busy_at_done", busy, 1'b1);
    check_eq("timeout_err", timeout_err, exp_terr);
    check_eq("resp_err", resp_err, exp_rerr);
    check_eq("response", response, exp_resp);
    @(negedge CLK);
    check_eq("done_clear", done, 1'b0);
    check_eq("busy_clear", busy, 1'b0);
    check_eq("terr_hold", timeout_err, exp_terr);
    check_eq("resp_hold", response, exp_resp);
  endtask

  initial begin
    int d, r;
    RESET = 1'b1; req = 1'b0; finished = 1'b0; cmd_line_in = 1'b1; receive_done = 1'b0;
    cmd_index = '0; cmd_argument = '0; resp_type = '0; response_in = '0;
    repeat (3) @(negedge CLK);
    check_reset_state("reset");
    RESET = 1'b0;
    @(negedge CLK);

    run_cmd(6'd0, 32'h0, 2'b00, 0, 0, 1'b0, '0, 48'h40_0000_0000_95, 1'b0, 1'b0);
    run_cmd(6'd8, 32'h1AA, 2'b01, 10, 3, 1'b1, 136'h08_0000_01AA_13, 48'h48_0000_01AA_87, 1'b0, 1'b0);
    run_cmd(6'd2, 32'h0, 2'b10, NCR_MAX, 0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_cmd(6'd55, 32'h0, 2'b01, 5, 2, 1'b1, 136'h37_0000_0001_20, 48'h77_0000_0000_65, 1'b0, 1'b0);
    run_cmd(6'd17, $urandom, 2'b01, 1000, 0, 1'b0, '0, '0, 1'b1, 1'b1);
    run_cmd(6'd0, 32'h0, 2'b00, 0, 0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_cmd(6'd9, $urandom, 2'b11, NCR_MAX - 1, 0, 1'b0, '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      d = ($urandom_range(0, 9) == 0) ? NCR_MAX : $urandom_range(0, 20);
      r = ($urandom_range(0, 9) == 0) ? RX_MAX : $urandom_range(0, 12);
      run_cmd(6'($urandom), $urandom, 2'($urandom), d, r, 1'b0, '0, '0, 1'($urandom_range(0, 1)), 1'b0);
    end

    run_cmd(6'd13, $urandom, 2'b01, 4, 0, 1'b1, 136'h0D_0000_0900_01, '0, 1'b0, 1'b0);
    run_cmd(6'd13, $urandom, 2'b01, 4, RX_MAX, 1'b0, '0, '0, 1'b0, 1'b0);
    run_cmd(6'd13, $urandom, 2'b01, 4, RX_MAX - 1, 1'b0, '0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
